// File: rtl/vector_pack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vector_pack_ctrl
// Description : Builds a V-bit vector by inserting a handshaked stream of
//               N-bit scalars lane by lane into a latched base vector.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_pack_ctrl #(
    parameter int V = 128,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [V-1:0] base_vec,
    input  logic [1:0]   start_lane,
    input  logic [2:0]   lane_count,
    input  logic         elem_valid,
    input  logic [N-1:0] elem_data,
    output logic         elem_ready,
    output logic [1:0]   lane_sel,
    output logic         vec_valid,
    output logic [V-1:0] vec_data,
    input  logic         vec_ready,
    output logic         busy,
    output logic         err
);

    localparam int LANES = V / N;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [V-1:0] r_acc;
    logic [1:0]   r_lane;
    logic [2:0]   r_rem;
    logic         r_err;

    logic         w_start_ok;
    logic         w_start_bad;
    logic         w_accept;
    logic [V-1:0] w_acc_ins;

    assign w_start_ok  = start && (lane_count != 3'd0) && (lane_count <= 3'd4);
    assign w_start_bad = start && !w_start_ok;
    assign w_accept    = (r_state == S_LOAD) && elem_valid;

    // Accumulator with the current lane replaced by the incoming scalar.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_acc_ins[N*k +: N] = (r_lane == 2'(k)) ? elem_data : r_acc[N*k +: N];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_lane  <= 2'd0;
            r_rem   <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= (r_state == S_IDLE) && w_start_bad;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_acc  <= base_vec;
                        r_lane <= start_lane;
                        r_rem  <= lane_count;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_acc  <= w_acc_ins;
                        r_lane <= r_lane + 2'd1;
                        r_rem  <= r_rem - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        elem_ready   = 1'b0;
        lane_sel     = 2'd0;
        vec_valid    = 1'b0;
        vec_data     = '0;
        busy         = (r_state != S_IDLE);
        err          = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                elem_ready = 1'b1;
                lane_sel   = r_lane;
                if (w_accept && (r_rem == 3'd1)) w_state_next = S_DONE;
            end
            S_DONE: begin
                vec_valid = 1'b1;
                vec_data  = r_acc;
                if (vec_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_pack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_pack_ctrl
// Description : Self-checking bench for vector_pack_ctrl with a lane-level
//               reference model and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_pack_ctrl;

    localparam int V = 128;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [V-1:0] base_vec;
    logic [1:0]   start_lane;
    logic [2:0]   lane_count;
    logic         elem_valid;
    logic [N-1:0] elem_data;
    logic         elem_ready;
    logic [1:0]   lane_sel;
    logic         vec_valid;
    logic [V-1:0] vec_data;
    logic         vec_ready;
    logic         busy;
    logic         err;

    int checks   = 0;
    int failures = 0;

    vector_pack_ctrl #(.V(V), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_vec   (base_vec),
        .start_lane (start_lane),
        .lane_count (lane_count),
        .elem_valid (elem_valid),
        .elem_data  (elem_data),
        .elem_ready (elem_ready),
        .lane_sel   (lane_sel),
        .vec_valid  (vec_valid),
        .vec_data   (vec_data),
        .vec_ready  (vec_ready),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Element i lands in lane (start + i) mod 4; untouched lanes keep base.
    function automatic logic [V-1:0] model_pack(input logic [V-1:0] base, input int sl,
                                                input int cnt, input logic [N-1:0] el [4]);
        logic [V-1:0] v;
        v = base;
        for (int i = 0; i < cnt; i++) v[((sl + i) % 4) * N +: N] = el[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_vec = '0; start_lane = 2'd0; lane_count = 3'd0;
        elem_valid = 1'b0; elem_data = '0; vec_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, vec_valid, elem_ready, err, lane_sel} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, want 000000", {busy, vec_valid, elem_ready, err, lane_sel});
        end
        checks++;
        if (vec_data !== '0) begin
            failures++;
            $display("FAIL reset_vec: got %h, want 0", vec_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_pack();
        logic [N-1:0] el [4];
        logic [V-1:0] exp_v;
        int           lat;
        el[0] = 32'h11111111; el[1] = 32'h22222222; el[2] = 32'h33333333; el[3] = 32'h44444444;
        exp_v = model_pack('0, 0, 4, el);
        base_vec = '0; start_lane = 2'd0; lane_count = 3'd4; start = 1'b1;
        elem_valid = 1'b1; elem_data = el[0];
        lat = 0;
        tick(); lat++;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            elem_data = el[i];
            checks++;
            if (lane_sel !== 2'(i) || elem_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_lane_sel[%0d]: got sel=%0d rdy=%b, want sel=%0d rdy=1", i, lane_sel, elem_ready, i);
            end
            tick(); lat++;
        end
        elem_valid = 1'b0;
        checks++;
        if (vec_valid !== 1'b1 || lat != 5) begin
            failures++;
            $display("FAIL full_latency: got vec_valid=%b at cycle %0d, want 1 at cycle 5", vec_valid, lat);
        end
        checks++;
        if (vec_data !== exp_v) begin
            failures++;
            $display("FAIL full_vec: got %h, want %h", vec_data, exp_v);
        end
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || vec_valid !== 1'b0 || vec_data !== '0) begin
            failures++;
            $display("FAIL full_idle: got busy=%b vec_valid=%b, want 0 0", busy, vec_valid);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] el [4];
        logic [V-1:0] exp_v;
        el[0] = 32'hA; el[1] = 32'hB; el[2] = '0; el[3] = '0;
        exp_v = model_pack({V{1'b1}}, 3, 2, el);
        base_vec = {V{1'b1}}; start_lane = 2'd3; lane_count = 3'd2; start = 1'b1;
        tick();
        start = 1'b0; elem_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            elem_data = el[i];
            checks++;
            if (lane_sel !== 2'((3 + i) % 4)) begin
                failures++;
                $display("FAIL wrap_lane_sel[%0d]: got %0d, want %0d", i, lane_sel, (3 + i) % 4);
            end
            tick();
        end
        elem_valid = 1'b0;
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== exp_v) begin
            failures++;
            $display("FAIL wrap_vec: got valid=%b data=%h, want 1 %h", vec_valid, vec_data, exp_v);
        end
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
    endtask

    task automatic test_stalls();
        logic [N-1:0] el [4];
        logic [V-1:0] exp_v;
        int           acc;
        int           pat [6];
        pat = '{1, 0, 0, 1, 1, 1};
        for (int i = 0; i < 4; i++) el[i] = $urandom;
        base_vec = {$urandom, $urandom, $urandom, $urandom};
        exp_v = model_pack(base_vec, 1, 4, el);
        start_lane = 2'd1; lane_count = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            elem_valid = pat[c][0];
            elem_data  = el[acc];
            checks++;
            if (lane_sel !== 2'((1 + acc) % 4) || busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_lane_sel[%0d]: got sel=%0d busy=%b, want sel=%0d busy=1", c, lane_sel, busy, (1 + acc) % 4);
            end
            tick();
            if (pat[c] == 1) acc++;
        end
        elem_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (vec_valid !== 1'b1 || vec_data !== exp_v) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h, want 1 %h", c, vec_valid, vec_data, exp_v);
            end
            tick();
        end
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || vec_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: got busy=%b valid=%b, want 0 0", busy, vec_valid);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad [2];
        bad = '{3'd0, 3'd5};
        for (int i = 0; i < 2; i++) begin
            lane_count = bad[i]; start_lane = 2'd0; start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || elem_ready !== 1'b0) begin
                failures++;
                $display("FAIL illegal_pulse[%0d]: got err=%b busy=%b rdy=%b, want 1 0 0", i, err, busy, elem_ready);
            end
            tick();
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL illegal_clear[%0d]: got err=%b busy=%b, want 0 0", i, err, busy);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [N-1:0] el [4];
        logic [V-1:0] exp_v;
        el[0] = 32'hCAFE0001; el[1] = 32'hCAFE0002; el[2] = '0; el[3] = '0;
        base_vec = '0;
        exp_v = model_pack('0, 2, 2, el);
        start_lane = 2'd2; lane_count = 3'd2; start = 1'b1;
        tick();
        base_vec = {V{1'b1}}; start_lane = 2'd0; lane_count = 3'd4;
        elem_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            elem_data = el[i];
            tick();
        end
        elem_valid = 1'b0;
        lane_count = 3'd0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (vec_valid !== 1'b1 || vec_data !== exp_v || err !== 1'b0) begin
                failures++;
                $display("FAIL ignored_start[%0d]: got valid=%b err=%b data=%h, want 1 0 %h", c, vec_valid, err, vec_data, exp_v);
            end
            tick();
        end
        start = 1'b0;
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL ignored_exit: got busy=%b err=%b, want 0 0", busy, err);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] el [4];
        logic [V-1:0] exp_v;
        base_vec = {V{1'b1}}; start_lane = 2'd0; lane_count = 3'd4; start = 1'b1;
        tick();
        start = 1'b0; elem_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            elem_data = $urandom;
            tick();
        end
        elem_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, vec_valid, elem_ready, err, lane_sel} !== 6'b0 || vec_data !== '0) begin
            failures++;
            $display("FAIL reset_mid: got ctrl=%b data=%h, want 000000 0", {busy, vec_valid, elem_ready, err, lane_sel}, vec_data);
        end
        el[0] = 32'h5A5A5A5A; el[1] = '0; el[2] = '0; el[3] = '0;
        base_vec = {32'h4, 32'h3, 32'h2, 32'h1};
        exp_v = model_pack(base_vec, 2, 1, el);
        start_lane = 2'd2; lane_count = 3'd1; start = 1'b1;
        tick();
        start = 1'b0; elem_valid = 1'b1; elem_data = el[0];
        tick();
        elem_valid = 1'b0;
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== exp_v) begin
            failures++;
            $display("FAIL reset_recover: got valid=%b data=%h, want 1 %h", vec_valid, vec_data, exp_v);
        end
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] el [4];
        logic [V-1:0] exp_v;
        int           sl, cnt, acc, guard;
        bit           done;
        for (int t = 0; t < 25; t++) begin
            sl  = $urandom_range(0, 3);
            cnt = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) el[i] = $urandom;
            base_vec = {$urandom, $urandom, $urandom, $urandom};
            exp_v = model_pack(base_vec, sl, cnt, el);
            start_lane = 2'(sl); lane_count = 3'(cnt); start = 1'b1;
            tick();
            start = 1'b0;
            acc = 0; guard = 0;
            while (acc < cnt && guard < 200) begin
                elem_valid = 1'($urandom_range(0, 1));
                elem_data  = el[acc];
                checks++;
                if (lane_sel !== 2'((sl + acc) % 4)) begin
                    failures++;
                    $display("FAIL rand_lane_sel[%0d]: got %0d, want %0d", t, lane_sel, (sl + acc) % 4);
                end
                tick();
                if (elem_valid) acc++;
                guard++;
            end
            elem_valid = 1'b0;
            done = 1'b0; guard = 0;
            while (!done && guard < 50) begin
                vec_ready = 1'($urandom_range(0, 1));
                checks++;
                if (vec_valid !== 1'b1 || vec_data !== exp_v) begin
                    failures++;
                    $display("FAIL rand_vec[%0d]: got valid=%b data=%h, want 1 %h", t, vec_valid, vec_data, exp_v);
                end
                tick();
                if (vec_ready) done = 1'b1;
                guard++;
            end
            vec_ready = 1'b0;
            checks++;
            if (!done || busy !== 1'b0) begin
                failures++;
                $display("FAIL rand_end[%0d]: got done=%b busy=%b, want 1 0", t, done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_pack();
        test_wrap();
        test_stalls();
        test_illegal();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
